// File: rtl/ssm_tile_feed_ctrl.sv
// Feeds lambda and x_t tiles from two 1-cycle-latency read buffers into the join stage.
// Each stream has its own issue counter, in-flight flag and 2-entry output FIFO.
module ssm_tile_feed_ctrl #(
  parameter int unsigned TILE_SIZE  = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [CNT_W-1:0]                     cfg_num_tiles,
  input  logic [ADDR_W-1:0]                    cfg_lam_base,
  input  logic [ADDR_W-1:0]                    cfg_xt_base,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 lam_rd_en,
  output logic [ADDR_W-1:0]                    lam_rd_addr,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] lam_rd_data,
  output logic                                 xt_rd_en,
  output logic [ADDR_W-1:0]                    xt_rd_addr,
  input  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] xt_rd_data,
  output logic                                 lam_valid,
  input  logic                                 lam_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] lam_vec,
  output logic                                 xt_valid,
  input  logic                                 xt_ready,
  output logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] xt_vec,
  input  logic                                 join_fire
);

  localparam int unsigned CW = CNT_W + 1;

  typedef logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] tile_t;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [CW-1:0]     num_tiles;
  logic [CW-1:0]     fired;
  logic [ADDR_W-1:0] lam_base;
  logic [ADDR_W-1:0] xt_base;
  logic              launch;

  logic [1:0]        rd_en_v;
  logic [1:0]        valid_v;
  logic [1:0]        ready_v;
  logic [ADDR_W-1:0] base_a    [2];
  logic [ADDR_W-1:0] rd_addr_a [2];
  tile_t             rd_data_a [2];
  tile_t             vec_a     [2];

  assign launch = (state == S_IDLE) && start;

  assign base_a[0]    = lam_base;
  assign base_a[1]    = xt_base;
  assign rd_data_a[0] = lam_rd_data;
  assign rd_data_a[1] = xt_rd_data;
  assign ready_v      = {xt_ready, lam_ready};

  assign lam_rd_en   = rd_en_v[0];
  assign lam_rd_addr = rd_addr_a[0];
  assign lam_valid   = valid_v[0];
  assign lam_vec     = vec_a[0];
  assign xt_rd_en    = rd_en_v[1];
  assign xt_rd_addr  = rd_addr_a[1];
  assign xt_valid    = valid_v[1];
  assign xt_vec      = vec_a[1];

  for (genvar s = 0; s < 2; s++) begin : g_stream
    logic [CW-1:0] issued;
    logic          inflight;
    logic [1:0]    occ;
    logic          wr_ptr;
    logic          rd_ptr;
    logic          pop;
    tile_t         mem [2];

    // Credit counts buffered plus in-flight tiles; ready never feeds back into issue.
    assign rd_en_v[s]   = (state == S_RUN) && (issued < num_tiles) &&
                          ((occ + {1'b0, inflight}) < 2'd2);
    assign rd_addr_a[s] = base_a[s] + ADDR_W'(issued);
    assign valid_v[s]   = (occ != 2'd0);
    assign vec_a[s]     = mem[rd_ptr];
    assign pop          = valid_v[s] && ready_v[s];

    always_ff @(posedge clk) begin
      if (rst || launch) begin
        issued   <= '0;
        inflight <= 1'b0;
        occ      <= 2'd0;
        wr_ptr   <= 1'b0;
        rd_ptr   <= 1'b0;
      end else begin
        inflight <= rd_en_v[s];
        if (rd_en_v[s]) issued <= issued + CW'(1);
        if (inflight)   wr_ptr <= ~wr_ptr;
        if (pop)        rd_ptr <= ~rd_ptr;
        occ <= occ + {1'b0, inflight} - {1'b0, pop};
      end
    end

    // Storage is not reset; in-flight is cleared on reset so stale returns are dropped.
    always_ff @(posedge clk) begin
      if (inflight) mem[wr_ptr] <= rd_data_a[s];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      num_tiles <= '0;
      fired     <= '0;
      lam_base  <= '0;
      xt_base   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            num_tiles <= CW'(cfg_num_tiles);
            lam_base  <= cfg_lam_base;
            xt_base   <= cfg_xt_base;
            fired     <= '0;
            busy      <= 1'b1;
            if (cfg_num_tiles == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (join_fire) begin
            fired <= fired + CW'(1);
            if ((fired + CW'(1)) == num_tiles) begin
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ssm_tile_feed_ctrl.sv
// Directed bench for ssm_tile_feed_ctrl: buffer model, pairing join model and
// an address/data scoreboard driven from hand-set expectations.
module tb_ssm_tile_feed_ctrl;

  typedef logic [3:0][15:0] tile_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] cfg_num_tiles;
  logic [7:0] cfg_lam_base;
  logic [7:0] cfg_xt_base;
  logic       busy;
  logic       done;
  logic       lam_rd_en;
  logic [7:0] lam_rd_addr;
  tile_t      lam_rd_data;
  logic       xt_rd_en;
  logic [7:0] xt_rd_addr;
  tile_t      xt_rd_data;
  logic       lam_valid;
  logic       lam_ready;
  tile_t      lam_vec;
  logic       xt_valid;
  logic       xt_ready;
  tile_t      xt_vec;
  logic       join_fire;
  logic       go;
  logic       pair;

  int n_cmp = 0;
  int n_err = 0;

  logic       mon_en = 1'b0;
  int         exp_n;
  logic [7:0] exp_lb;
  logic [7:0] exp_xb;
  int         lam_iss, xt_iss, lam_pop, xt_pop, done_cnt;
  int         cyc;

  always #5 clk = ~clk;

  ssm_tile_feed_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cfg_num_tiles (cfg_num_tiles),
    .cfg_lam_base  (cfg_lam_base),
    .cfg_xt_base   (cfg_xt_base),
    .busy          (busy),
    .done          (done),
    .lam_rd_en     (lam_rd_en),
    .lam_rd_addr   (lam_rd_addr),
    .lam_rd_data   (lam_rd_data),
    .xt_rd_en      (xt_rd_en),
    .xt_rd_addr    (xt_rd_addr),
    .xt_rd_data    (xt_rd_data),
    .lam_valid     (lam_valid),
    .lam_ready     (lam_ready),
    .lam_vec       (lam_vec),
    .xt_valid      (xt_valid),
    .xt_ready      (xt_ready),
    .xt_vec        (xt_vec),
    .join_fire     (join_fire)
  );

  function automatic tile_t lam_word(input logic [7:0] a);
    tile_t t;
    for (int i = 0; i < 4; i++) t[i] = {4'hA, a, 4'(i)};
    return t;
  endfunction

  function automatic tile_t xt_word(input logic [7:0] a);
    tile_t t;
    for (int i = 0; i < 4; i++) t[i] = {4'h5, a, 4'(i)};
    return t;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Buffer model: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (lam_rd_en) lam_rd_data <= lam_word(lam_rd_addr);
    if (xt_rd_en)  xt_rd_data  <= xt_word(xt_rd_addr);
  end

  // Join model: consumes both tiles together, reports the output handshake a cycle later.
  assign pair      = go && lam_valid && xt_valid;
  assign lam_ready = pair;
  assign xt_ready  = pair;
  always @(posedge clk) join_fire <= rst ? 1'b0 : pair;

  always @(negedge clk) begin
    if (mon_en) begin
      if (lam_rd_en) begin
        check("lam_rd_addr", 64'(lam_rd_addr), 64'(8'(exp_lb + 8'(lam_iss))));
        lam_iss++;
      end
      if (xt_rd_en) begin
        check("xt_rd_addr", 64'(xt_rd_addr), 64'(8'(exp_xb + 8'(xt_iss))));
        xt_iss++;
      end
      if (lam_valid && lam_ready) begin
        check("lam_vec", lam_vec, lam_word(8'(exp_lb + 8'(lam_pop))));
        lam_pop++;
      end
      if (xt_valid && xt_ready) begin
        check("xt_vec", xt_vec, xt_word(8'(exp_xb + 8'(xt_pop))));
        xt_pop++;
      end
      if (done) done_cnt++;
    end
  end

  // Pulses start for one cycle; returns in cycle 1 of the run.
  task automatic begin_test(input int n, input logic [7:0] lb, input logic [7:0] xb);
    exp_n    = n;
    exp_lb   = lb;
    exp_xb   = xb;
    lam_iss  = 0;
    xt_iss   = 0;
    lam_pop  = 0;
    xt_pop   = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    cfg_num_tiles = 8'(n);
    cfg_lam_base  = lb;
    cfg_xt_base   = xb;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic finish_test(input string tag, output int done_cyc);
    int k = 0;
    while (!done && k < 60) begin
      tick();
      k++;
    end
    check({tag, "_done_seen"}, 64'(done), 64'd1);
    done_cyc = cyc;
    check({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    tick();
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
    check({tag, "_done_after"}, 64'(done), 64'd0);
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'(1));
    check({tag, "_lam_issued"}, 64'(lam_iss), 64'(exp_n));
    check({tag, "_xt_issued"}, 64'(xt_iss), 64'(exp_n));
    check({tag, "_lam_popped"}, 64'(lam_pop), 64'(exp_n));
    check({tag, "_xt_popped"}, 64'(xt_pop), 64'(exp_n));
    mon_en = 1'b0;
  endtask

  initial begin
    int dc;
    rst = 1'b1;
    start = 1'b0;
    go = 1'b1;
    cfg_num_tiles = '0;
    cfg_lam_base = '0;
    cfg_xt_base = '0;
    lam_rd_data = '0;
    xt_rd_data = '0;
    cyc = 0;
    tick();
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lam_valid", 64'(lam_valid), 64'd0);
    check("rst_xt_valid", 64'(xt_valid), 64'd0);
    check("rst_lam_rd_en", 64'(lam_rd_en), 64'd0);
    check("rst_xt_rd_en", 64'(xt_rd_en), 64'd0);
    rst = 1'b0;
    tick();

    // Basic run, N=3: first reads in cycle 1, done in cycle 8.
    begin_test(3, 8'h10, 8'h40);
    check("t1_busy_c1", 64'(busy), 64'd1);
    check("t1_lam_en_c1", 64'(lam_rd_en), 64'd1);
    check("t1_lam_addr_c1", 64'(lam_rd_addr), 64'h10);
    check("t1_xt_addr_c1", 64'(xt_rd_addr), 64'h40);
    tick();
    check("t1_lam_addr_c2", 64'(lam_rd_addr), 64'h11);
    check("t1_lam_valid_c2", 64'(lam_valid), 64'd0);
    tick();
    check("t1_lam_valid_c3", 64'(lam_valid), 64'd1);
    check("t1_lam_en_c3", 64'(lam_rd_en), 64'd0);
    finish_test("t1", dc);
    check("t1_done_cycle", 64'(dc), 64'(8));

    // Join stalled for 6 cycles: each stream stops after 2 issues.
    go = 1'b0;
    begin_test(4, 8'h00, 8'h80);
    repeat (5) tick();
    check("t2_lam_iss_stall", 64'(lam_iss), 64'(2));
    check("t2_xt_iss_stall", 64'(xt_iss), 64'(2));
    check("t2_lam_en_stall", 64'(lam_rd_en), 64'd0);
    check("t2_xt_en_stall", 64'(xt_rd_en), 64'd0);
    check("t2_lam_valid_stall", 64'(lam_valid), 64'd1);
    check("t2_xt_valid_stall", 64'(xt_valid), 64'd1);
    check("t2_no_done_stall", 64'(done_cnt), 64'(0));
    go = 1'b1;
    finish_test("t2", dc);

    // Zero tiles: done in cycle 1, no reads.
    begin_test(0, 8'h33, 8'h44);
    check("t3_done_c1", 64'(done), 64'd1);
    check("t3_lam_en_c1", 64'(lam_rd_en), 64'd0);
    check("t3_xt_en_c1", 64'(xt_rd_en), 64'd0);
    finish_test("t3", dc);
    check("t3_done_cycle", 64'(dc), 64'(1));

    // Address wrap on the lambda side.
    begin_test(4, 8'hFE, 8'h00);
    check("t4_lam_addr_c1", 64'(lam_rd_addr), 64'hFE);
    finish_test("t4", dc);

    // Reset mid-run with a read in flight and another being issued.
    go = 1'b0;
    begin_test(4, 8'h30, 8'h70);
    tick();
    check("t5_lam_en_c2", 64'(lam_rd_en), 64'd1);
    mon_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy_after_rst", 64'(busy), 64'd0);
    check("t5_lam_valid_after_rst", 64'(lam_valid), 64'd0);
    check("t5_xt_valid_after_rst", 64'(xt_valid), 64'd0);
    check("t5_lam_en_after_rst", 64'(lam_rd_en), 64'd0);
    check("t5_xt_en_after_rst", 64'(xt_rd_en), 64'd0);
    tick();
    check("t5_lam_valid_drop", 64'(lam_valid), 64'd0);
    check("t5_xt_valid_drop", 64'(xt_valid), 64'd0);
    go = 1'b1;
    begin_test(2, 8'h05, 8'h07);
    finish_test("t5", dc);

    // A second start mid-run must not reload the configuration.
    begin_test(3, 8'h20, 8'h60);
    tick();
    cfg_num_tiles = 8'd5;
    cfg_lam_base  = 8'h80;
    cfg_xt_base   = 8'h90;
    start = 1'b1;
    tick();
    start = 1'b0;
    finish_test("t6", dc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
